baw_hand_tracker: RTL and testbench

- Per-round card-commit stage that sits directly upstream of the match comparator in the black-and-white card game top level.
- Validates each player's switch selection and enforces single use of every card per game.
- Latches p1_handcard / p2_handcard for the comparator.
- Exposes each held card's colour (black/white) for the opponent-facing LED hint.

---
 rtl/baw_hand_tracker.sv | 150 +++++++++++++++
 tb/tb_baw_hand_tracker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/baw_hand_tracker.sv
// Per-round card-commit stage: validates each player's switch selection,
// enforces single use of every card per game and holds the committed cards.
module baw_hand_tracker #(
  parameter int NCARDS = 9,
  parameter int SW_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              new_game,
  input  logic              round_clear,
  input  logic              p1_commit,
  input  logic              p2_commit,
  input  logic [SW_W-1:0]   sw,
  output logic [3:0]        p1_handcard,
  output logic [3:0]        p2_handcard,
  output logic              p1_valid,
  output logic              p2_valid,
  output logic              p1_color,
  output logic              p2_color,
  output logic              both_ready,
  output logic              match_go,
  output logic [NCARDS-1:0] p1_used,
  output logic [NCARDS-1:0] p2_used,
  output logic [3:0]        p1_left,
  output logic [3:0]        p2_left,
  output logic              reject,
  output logic [1:0]        reject_code
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} slotState_t;

  localparam logic [3:0] FULL_DECK = 4'(NCARDS);

  slotState_t        slotState [2];
  slotState_t        slotStateNext [2];
  logic [3:0]        hand [2];
  logic [3:0]        handNext [2];
  logic [NCARDS-1:0] used [2];
  logic [NCARDS-1:0] usedNext [2];
  logic [3:0]        left [2];
  logic [3:0]        leftNext [2];
  logic [1:0]        refuseCode [2];
  logic [1:0]        commit;
  logic              rejectReg, rejectNext;
  logic [1:0]        rejectCodeReg, rejectCodeNext;
  logic              bothPrev;
  logic              upperClear, oneHot;
  logic [NCARDS-1:0] selMask;
  logic [3:0]        selIdx;

  assign commit     = {p2_commit, p1_commit};
  assign selMask    = sw[NCARDS-1:0];
  assign upperClear = ((sw >> NCARDS) == '0);
  assign oneHot     = $onehot(selMask);

  always_comb begin
    selIdx = 4'd0;
    for (int i = 0; i < NCARDS; i++) begin
      if (selMask[i]) selIdx = 4'(i);
    end
  end

  // Next-state: new_game beats round_clear beats commits; a commit that
  // coincides with either clear is dropped without a reject.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      slotStateNext[p] = slotState[p];
      handNext[p]      = hand[p];
      usedNext[p]      = used[p];
      leftNext[p]      = left[p];
      refuseCode[p]    = 2'd0;
    end
    rejectNext     = 1'b0;
    rejectCodeNext = rejectCodeReg;

    if (new_game) begin
      for (int p = 0; p < 2; p++) begin
        slotStateNext[p] = EMPTY;
        handNext[p]      = 4'd0;
        usedNext[p]      = '0;
        leftNext[p]      = FULL_DECK;
      end
      rejectCodeNext = 2'd0;
    end else if (round_clear) begin
      for (int p = 0; p < 2; p++) begin
        slotStateNext[p] = EMPTY;
        handNext[p]      = 4'd0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (commit[p]) begin
          if (slotState[p] == HELD)            refuseCode[p] = 2'd3;
          else if (!upperClear || !oneHot)     refuseCode[p] = 2'd1;
          else if ((selMask & used[p]) != '0)  refuseCode[p] = 2'd2;
          else begin
            slotStateNext[p] = HELD;
            handNext[p]      = selIdx;
            usedNext[p]      = used[p] | selMask;
            leftNext[p]      = left[p] - 4'd1;
          end
        end
      end
      // Player 1's reason wins when both players are refused together.
      if (refuseCode[1] != 2'd0) rejectCodeNext = refuseCode[1];
      if (refuseCode[0] != 2'd0) rejectCodeNext = refuseCode[0];
      rejectNext = (refuseCode[0] != 2'd0) || (refuseCode[1] != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int p = 0; p < 2; p++) begin
        slotState[p] <= EMPTY;
        hand[p]      <= 4'd0;
        used[p]      <= '0;
        left[p]      <= FULL_DECK;
      end
      rejectReg     <= 1'b0;
      rejectCodeReg <= 2'd0;
      bothPrev      <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        slotState[p] <= slotStateNext[p];
        hand[p]      <= handNext[p];
        used[p]      <= usedNext[p];
        left[p]      <= leftNext[p];
      end
      rejectReg     <= rejectNext;
      rejectCodeReg <= rejectCodeNext;
      bothPrev      <= both_ready;
    end
  end

  assign p1_handcard = hand[0];
  assign p2_handcard = hand[1];
  assign p1_valid    = (slotState[0] == HELD);
  assign p2_valid    = (slotState[1] == HELD);
  // Hand is zeroed whenever the slot empties, so bit 0 doubles as colour.
  assign p1_color    = hand[0][0];
  assign p2_color    = hand[1][0];
  assign both_ready  = p1_valid & p2_valid;
  assign match_go    = both_ready & ~bothPrev;
  assign p1_used     = used[0];
  assign p2_used     = used[1];
  assign p1_left     = left[0];
  assign p2_left     = left[1];
  assign reject      = rejectReg;
  assign reject_code = rejectCodeReg;

endmodule

// File: tb/tb_baw_hand_tracker.sv
// Directed bench for baw_hand_tracker: each driven cycle queues a hand-written
// expected output snapshot that a monitor compares after the next clock edge.
module tb_baw_hand_tracker;

  logic        clk;
  logic        resetn, new_game, round_clear, p1_commit, p2_commit;
  logic [15:0] sw;
  logic [3:0]  p1_handcard, p2_handcard, p1_left, p2_left;
  logic        p1_valid, p2_valid, p1_color, p2_color, both_ready, match_go, reject;
  logic [8:0]  p1_used, p2_used;
  logic [1:0]  reject_code;

  baw_hand_tracker #(.NCARDS(9), .SW_W(16)) dut (
    .clk(clk), .resetn(resetn), .new_game(new_game), .round_clear(round_clear),
    .p1_commit(p1_commit), .p2_commit(p2_commit), .sw(sw),
    .p1_handcard(p1_handcard), .p2_handcard(p2_handcard),
    .p1_valid(p1_valid), .p2_valid(p2_valid),
    .p1_color(p1_color), .p2_color(p2_color),
    .both_ready(both_ready), .match_go(match_go),
    .p1_used(p1_used), .p2_used(p2_used),
    .p1_left(p1_left), .p2_left(p2_left),
    .reject(reject), .reject_code(reject_code)
  );

  typedef struct packed {
    logic [3:0] h1, h2;
    logic       v1, v2, c1, c2, both, go;
    logic [8:0] u1, u2;
    logic [3:0] l1, l2;
    logic       rej;
    logic [1:0] code;
  } snap_t;

  snap_t expQ[$];
  string nameQ[$];
  snap_t exp;
  int    total = 0;
  int    bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (expQ.size() > 0) begin
      snap_t e, a;
      string nm;
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      a  = '{p1_handcard, p2_handcard, p1_valid, p2_valid, p1_color, p2_color,
             both_ready, match_go, p1_used, p2_used, p1_left, p2_left,
             reject, reject_code};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got h=%0d/%0d v=%b%b c=%b%b both=%b go=%b used=%h/%h left=%0d/%0d rej=%b code=%0d ; want h=%0d/%0d v=%b%b c=%b%b both=%b go=%b used=%h/%h left=%0d/%0d rej=%b code=%0d",
                 nm, a.h1, a.h2, a.v1, a.v2, a.c1, a.c2, a.both, a.go, a.u1, a.u2, a.l1, a.l2, a.rej, a.code,
                 e.h1, e.h2, e.v1, e.v2, e.c1, e.c2, e.both, e.go, e.u1, e.u2, e.l1, e.l2, e.rej, e.code);
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic ng, input logic rc,
                      input logic c1, input logic c2, input logic [15:0] s,
                      input logic eRej, input logic eGo);
    snap_t e;
    @(negedge clk);
    resetn = rn; new_game = ng; round_clear = rc;
    p1_commit = c1; p2_commit = c2; sw = s;
    e = exp;
    e.rej = eRej;
    e.go  = eGo;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic resetExp();
    exp = '0;
    exp.l1 = 4'd9;
    exp.l2 = 4'd9;
  endtask

  task automatic clearSlots();
    exp.h1 = 4'd0; exp.h2 = 4'd0; exp.v1 = 1'b0; exp.v2 = 1'b0;
    exp.c1 = 1'b0; exp.c2 = 1'b0; exp.both = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; new_game = 1'b0; round_clear = 1'b0;
    p1_commit = 1'b0; p2_commit = 1'b0; sw = 16'h0;
    resetExp();
    step("reset_a", 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    step("reset_b", 0, 0, 0, 1, 1, 16'h0010, 0, 0);

    exp.h1 = 4; exp.v1 = 1; exp.u1 = 9'h010; exp.l1 = 8;
    step("p1_take4", 1, 0, 0, 1, 0, 16'h0010, 0, 0);
    exp.h2 = 3; exp.v2 = 1; exp.c2 = 1; exp.u2 = 9'h008; exp.l2 = 8; exp.both = 1;
    step("p2_take3", 1, 0, 0, 0, 1, 16'h0008, 0, 1);
    step("go_once", 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    clearSlots();
    step("round_clear", 1, 0, 1, 0, 0, 16'h0000, 0, 0);

    exp.code = 2;
    step("reuse4", 1, 0, 0, 1, 0, 16'h0010, 1, 0);
    step("reject_drop", 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    exp.code = 1;
    step("two_bits", 1, 0, 0, 1, 0, 16'h0030, 1, 0);
    step("upper_bit", 1, 0, 0, 1, 0, 16'h1000, 1, 0);
    exp.v1 = 1; exp.h1 = 0; exp.u1 = 9'h011; exp.l1 = 7;
    step("p1_take0", 1, 0, 0, 1, 0, 16'h0001, 0, 0);
    exp.code = 3;
    step("held_recommit", 1, 0, 0, 1, 0, 16'h0002, 1, 0);
    step("held_two_bits", 1, 0, 0, 1, 0, 16'h0030, 1, 0);
    clearSlots();
    step("clear_drops", 1, 0, 1, 1, 1, 16'h0040, 0, 0);

    exp.h1 = 8; exp.h2 = 8; exp.v1 = 1; exp.v2 = 1; exp.both = 1;
    exp.u1 = 9'h111; exp.l1 = 6; exp.u2 = 9'h108; exp.l2 = 7;
    step("both_take8", 1, 0, 0, 1, 1, 16'h0100, 0, 1);
    step("go_hold", 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    clearSlots();
    step("round_clear2", 1, 0, 1, 0, 0, 16'h0000, 0, 0);

    exp.code = 1;
    step("bad_beats_used", 1, 0, 0, 1, 0, 16'h0011, 1, 0);
    exp.code = 2; exp.v2 = 1; exp.h2 = 0; exp.u2 = 9'h109; exp.l2 = 6;
    step("split_commit", 1, 0, 0, 1, 1, 16'h0001, 1, 0);
    exp.code = 1;
    step("both_refused", 1, 0, 0, 1, 1, 16'h0003, 1, 0);

    resetExp();
    step("new_game", 1, 1, 0, 0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 9; i++) begin
      exp.h1 = 4'(i); exp.v1 = 1; exp.c1 = i[0];
      exp.u1 = exp.u1 | (9'h001 << i); exp.l1 = 4'(8 - i);
      step("deck_take", 1, 0, 0, 1, 0, 16'h0001 << i, 0, 0);
      clearSlots();
      step("deck_clear", 1, 0, 1, 0, 0, 16'h0000, 0, 0);
    end
    exp.code = 2;
    step("exhausted", 1, 0, 0, 1, 0, 16'h0001, 1, 0);
    exp.code = 1;
    step("exhausted_bad", 1, 0, 0, 1, 0, 16'h0003, 1, 0);
    resetExp();
    step("newgame_drop", 1, 1, 0, 1, 0, 16'h0001, 0, 0);
    exp.h1 = 2; exp.v1 = 1; exp.u1 = 9'h004; exp.l1 = 8;
    step("after_newgame", 1, 0, 0, 1, 0, 16'h0004, 0, 0);
    resetExp();
    step("reset_midround", 0, 0, 0, 0, 1, 16'h0002, 0, 0);
    step("reset_hold", 0, 0, 0, 0, 0, 16'h0000, 0, 0);

    for (int k = 0; k < 20 && expQ.size() > 0; k++) @(negedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d snapshots unchecked, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
